// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned N_BITS = 32
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [N_BITS-1:0] a_i;
    logic [N_BITS-1:0] b_i;
    logic              mthi_i;
    logic              mtlo_i;
    logic [N_BITS-1:0] wdata_i;
    logic              mfhilo_i;
    logic              flush_i;
    logic              busy_o;
    logic              done_o;
    logic              stall_o;
    logic [N_BITS-1:0] hi_o;
    logic [N_BITS-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, mthi_i, mtlo_i, wdata_i, mfhilo_i, flush_i,
        input  busy_o, done_o, stall_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, mthi_i, mtlo_i, wdata_i, mfhilo_i, flush_i,
        output busy_o, done_o, stall_o, hi_o, lo_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, updated on the falling clock edge.
// Optional MDU_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int unsigned N_BITS = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned W     = N_BITS;
    localparam int unsigned CNT_W = $clog2(N_BITS);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [W-1:0]     a_q, b_q;
    logic [2*W-1:0]   acc_q, mcand_q;
    logic [W-1:0]     mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q, rneg_q;
    logic [W-1:0]     hi_q, lo_q, hi_d, lo_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [W-1:0]     mag_a_c, mag_b_c;
    logic [2*W-1:0]   prod_c;
    logic [W-1:0]     quo_c, rem_c;
    logic [W:0]       rem_sh_c, diff_c;
    logic             mul_early_c, prep_skip_c;

    // op_q[0] marks the signed variants, op_q[1] marks divide
    assign mag_a_c = (op_q[0] && a_q[W-1]) ? (~a_q + W'(1)) : a_q;
    assign mag_b_c = (op_q[0] && b_q[W-1]) ? (~b_q + W'(1)) : b_q;

    assign prod_c = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
    assign quo_c  = neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    assign rem_c  = rneg_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];

    // Restoring divide step: shift next dividend bit into the partial remainder and trial-subtract
    assign rem_sh_c = {acc_q[2*W-1:W], acc_q[W-1]};
    assign diff_c   = rem_sh_c - {1'b0, mcand_q[W-1:0]};

`ifdef MDU_EARLY_OUT_EN
    assign mul_early_c = !op_q[1] && (mplier_q[W-1:1] == '0);
    assign prep_skip_c = !op_q[1] && (mag_b_c == '0);
`else
    assign mul_early_c = 1'b0;
    assign prep_skip_c = 1'b0;
`endif

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mthi_i) hi_d = bus.wdata_i;
                if (bus.mtlo_i) lo_d = bus.wdata_i;
                if (bus.start_i && !bus.flush_i) begin
                    state_d = S_PREP;
                    busy_d  = 1'b1;
                end
            end
            S_PREP: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (prep_skip_c) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if ((cnt_q == CNT_W'(N_BITS - 1)) || mul_early_c) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!bus.flush_i) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_c[2*W-1:W];
                        lo_d = prod_c[W-1:0];
                    end else if (b_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_c;
                        lo_d = quo_c;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Operand capture and the shift-add / shift-subtract datapath
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_q <= bus.op_i;
                        a_q  <= bus.a_i;
                        b_q  <= bus.b_i;
                    end
                end
                S_PREP: begin
                    cnt_q  <= '0;
                    neg_q  <= op_q[0] && (a_q[W-1] ^ b_q[W-1]);
                    rneg_q <= op_q[0] && a_q[W-1];
                    if (op_q[1]) begin
                        acc_q   <= {W'(0), mag_a_c};
                        mcand_q <= {W'(0), mag_b_c};
                    end else begin
                        acc_q    <= '0;
                        mcand_q  <= {W'(0), mag_a_c};
                        mplier_q <= mag_b_c;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!op_q[1]) begin
                        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end else if (!diff_c[W]) begin
                        acc_q <= {diff_c[W-1:0], acc_q[W-2:0], 1'b1};
                    end else begin
                        acc_q <= {rem_sh_c[W-1:0], acc_q[W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.stall_o = busy_q & bus.mfhilo_i;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int unsigned N = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if #(.N_BITS(N)) bus ();
    mult_div_unit #(.N_BITS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_hi, exp_lo;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        longint p;
        sa = a;
        sb = b;
        case (op)
            2'b00: return {32'h0, a} * {32'h0, b};
            2'b01: begin
                p = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Edges from the start edge to the HI/LO write edge
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int msb;
        m = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
        msb = -1;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        if (EARLY && op[1] == 1'b0) return (msb < 0) ? 2 : 3 + msb;
        return N + 2;
    endfunction

    task automatic clear_inputs();
        bus.start_i  = 1'b0;
        bus.mthi_i   = 1'b0;
        bus.mtlo_i   = 1'b0;
        bus.flush_i  = 1'b0;
        bus.mfhilo_i = 1'b0;
    endtask

    // Issue one op with MFHI/MFLO pending in ID for its whole duration
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke_busy, input bit mt_start);
        logic [63:0] ref_v;
        int lat, k;
        bit held, stalled, done_early;
        ref_v = model(op, a, b);
        lat   = exp_lat(op, b);
        bus.op_i     = op;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.start_i  = 1'b1;
        bus.mfhilo_i = 1'b1;
        if (mt_start) begin
            bus.mthi_i  = 1'b1;
            bus.mtlo_i  = 1'b1;
            bus.wdata_i = 32'hA5A5_0F0F;
        end
        step();
        bus.start_i = 1'b0;
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
        bus.op_i    = ~op;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        chk({tag, " busy_after_start"}, 64'(bus.busy_o), 64'd1);
        if (mt_start) begin
            chk({tag, " mt_with_start_hi"}, 64'(bus.hi_o), 64'h0000_0000_A5A5_0F0F);
            exp_hi = 32'hA5A5_0F0F;
            exp_lo = 32'hA5A5_0F0F;
        end
        held = 1'b1;
        stalled = 1'b1;
        done_early = 1'b0;
        k = 0;
        while (bus.busy_o === 1'b1 && k < 80) begin
            if (poke_busy && k == 4) begin
                bus.start_i = 1'b1;
                bus.mthi_i  = 1'b1;
                bus.mtlo_i  = 1'b1;
                bus.wdata_i = 32'hDEAD_BEEF;
            end else begin
                bus.start_i = 1'b0;
                bus.mthi_i  = 1'b0;
                bus.mtlo_i  = 1'b0;
            end
            held  = held & (bus.hi_o === exp_hi) & (bus.lo_o === exp_lo);
            stalled = stalled & (bus.stall_o === 1'b1);
            done_early = done_early | (bus.done_o === 1'b1);
            step();
            k++;
        end
        bus.start_i = 1'b0;
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
        exp_hi = ref_v[63:32];
        exp_lo = ref_v[31:0];
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " hi"}, 64'(bus.hi_o), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus.lo_o), 64'(exp_lo));
        chk({tag, " done_pulse"}, 64'(bus.done_o), 64'd1);
        chk({tag, " hilo_held_while_busy"}, 64'(held), 64'd1);
        chk({tag, " stall_while_busy"}, 64'(stalled), 64'd1);
        chk({tag, " no_early_done"}, 64'(done_early), 64'd0);
        chk({tag, " stall_released"}, 64'(bus.stall_o), 64'd0);
        bus.mfhilo_i = 1'b0;
        step();
        chk({tag, " done_one_cycle"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        bit done_any;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        reset = 1'b0;
        bus.op_i = 2'b00;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.wdata_i = '0;
        clear_inputs();
        #12;
        chk("reset hi", 64'(bus.hi_o), 64'd0);
        chk("reset lo", 64'(bus.lo_o), 64'd0);
        chk("reset busy", 64'(bus.busy_o), 64'd0);
        chk("reset done", 64'(bus.done_o), 64'd0);
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        step();

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu_by0", 2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("div_by0_neg", 2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("multu_small", 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        run_op("mult_by0", 2'b01, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op("mult_mt_start", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);

        // MTHI/MTLO in IDLE, then a DIVU flushed mid-run keeps them
        bus.wdata_i = 32'h1234;
        bus.mthi_i = 1'b1;
        step();
        bus.mthi_i = 1'b0;
        bus.wdata_i = 32'h5678;
        bus.mtlo_i = 1'b1;
        step();
        bus.mtlo_i = 1'b0;
        chk("mthi idle", 64'(bus.hi_o), 64'h1234);
        chk("mtlo idle", 64'(bus.lo_o), 64'h5678);
        bus.op_i = 2'b10;
        bus.a_i = 32'd1000;
        bus.b_i = 32'd7;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        repeat (10) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush busy", 64'(bus.busy_o), 64'd0);
        done_any = 1'b0;
        for (int i = 0; i < 40; i++) begin
            done_any = done_any | (bus.done_o === 1'b1);
            step();
        end
        chk("flush no_done", 64'(done_any), 64'd0);
        chk("flush hi", 64'(bus.hi_o), 64'h1234);
        chk("flush lo", 64'(bus.lo_o), 64'h5678);

        // flush beats start in IDLE
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("flush_start busy", 64'(bus.busy_o), 64'd0);

        // asynchronous reset mid-MULT
        bus.op_i = 2'b01;
        bus.a_i = 32'hFFFF_FFF9;
        bus.b_i = 32'd3;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        repeat (20) step();
        #2 reset = 1'b0;
        #1;
        chk("midreset hi", 64'(bus.hi_o), 64'd0);
        chk("midreset lo", 64'(bus.lo_o), 64'd0);
        chk("midreset busy", 64'(bus.busy_o), 64'd0);
        #2 reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        repeat (3) step();
        chk("midreset stays_idle", 64'(bus.busy_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op("rand", rop, ra, rb, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
